// File: rtl/bmc_rx_decoder.sv
// ---------------------------------------------------------------------------
// bmc_rx_decoder
//
// Receive side of a USB-PD BMC link for the bench. Takes the digitized CC
// comparator output, synchronizes it, learns the unit interval (UI) from the
// preamble and then turns edge-to-edge intervals into bits. A full-UI interval
// is a 0; two consecutive half-UI intervals are a 1. Reception ends when the
// line has been quiet for IDLE_CYC cycles.
//
// Parameters
//   CNT_W     interval counter width (counter saturates at all-ones)
//   TRAIN_IV  preamble intervals summed for UI training (24 intervals = 16 UI)
//   IDLE_CYC  quiet cycles that terminate a reception
//
// Ports
//   clk         sample clock
//   rst         asynchronous active-high reset
//   en          receiver enable; low forces IDLE
//   comp_cc     asynchronous comparator output (CC > 550 mV)
//   rx_bit      decoded bit, qualified by rx_bit_vld
//   rx_bit_vld  one-cycle bit strobe
//   rx_active   high while training or receiving
//   cc_idle     high while idle (always ~rx_active)
//   rx_end      one-cycle pulse when a reception ends by timeout
//   rx_err      sticky error, cleared when the next packet starts
//   ui_len      trained UI in clock cycles, held until the next training
// ---------------------------------------------------------------------------
module bmc_rx_decoder #(
    parameter int CNT_W    = 8,
    parameter int TRAIN_IV = 24,
    parameter int IDLE_CYC = 160
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             comp_cc,
    output logic             rx_bit,
    output logic             rx_bit_vld,
    output logic             rx_active,
    output logic             cc_idle,
    output logic             rx_end,
    output logic             rx_err,
    output logic [CNT_W-1:0] ui_len
);

    // The accumulator holds TRAIN_IV intervals; 5 extra bits cover the sum.
    localparam int ACC_W = CNT_W + 5;
    localparam int IVN_W = $clog2(TRAIN_IV + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_TRAIN, ST_RECV} state_t;

    state_t           state, state_d;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [ACC_W-1:0] acc, acc_d, acc_sum;
    logic [IVN_W-1:0] iv_n, iv_n_d;
    logic             half_pend, half_pend_d;
    logic             rx_bit_d, rx_bit_vld_d, rx_end_d, rx_err_d;
    logic [CNT_W-1:0] ui_len_d;
    logic [CNT_W-1:0] thr, glitch_lim;
    logic             cc_edge, timeout;

    // s1 is the metastability stage; edges are taken between s2 and s3.
    assign cc_edge    = s2 ^ s3;
    // An edge in the same cycle as the timeout count wins.
    assign timeout    = !cc_edge && (cnt == CNT_W'(IDLE_CYC));
    // Anything shorter than 3/4 UI is a half interval; below 1/4 UI a glitch.
    assign thr        = ui_len - (ui_len >> 2);
    assign glitch_lim = ui_len >> 2;
    assign acc_sum    = acc + ACC_W'(cnt);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned; that keeps this block free of latches.
        state_d      = state;
        acc_d        = acc;
        iv_n_d       = iv_n;
        half_pend_d  = half_pend;
        rx_bit_d     = rx_bit;
        rx_bit_vld_d = 1'b0;
        rx_end_d     = 1'b0;
        rx_err_d     = rx_err;
        ui_len_d     = ui_len;

        // cnt measures the interval ending at each edge, independent of state.
        if (cc_edge) begin
            cnt_d = CNT_W'(1);
        end else if (cnt != '1) begin
            cnt_d = cnt + CNT_W'(1);
        end else begin
            cnt_d = cnt;
        end

        if (!en) begin
            // Disable returns the decoder to its reset-visible outputs but
            // keeps the trained UI.
            state_d     = ST_IDLE;
            half_pend_d = 1'b0;
            rx_err_d    = 1'b0;
            rx_bit_d    = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // First edge is the start of preamble bit 0.
                    if (cc_edge) begin
                        state_d     = ST_TRAIN;
                        acc_d       = '0;
                        iv_n_d      = '0;
                        half_pend_d = 1'b0;
                        rx_err_d    = 1'b0;
                    end
                end
                ST_TRAIN: begin
                    if (cc_edge) begin
                        acc_d  = acc_sum;
                        iv_n_d = iv_n + IVN_W'(1);
                        if (iv_n == IVN_W'(TRAIN_IV - 1)) begin
                            // TRAIN_IV preamble intervals span 16 UI.
                            ui_len_d = CNT_W'(acc_sum >> 4);
                            state_d  = ST_RECV;
                        end
                    end else if (timeout) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (cc_edge) begin
                        if (cnt < glitch_lim) begin
                            rx_err_d = 1'b1;
                        end
                        if (cnt >= thr) begin
                            // A full interval while a half is outstanding means
                            // the lone half was lost; flag it and resync.
                            if (half_pend) begin
                                rx_err_d = 1'b1;
                            end
                            half_pend_d  = 1'b0;
                            rx_bit_d     = 1'b0;
                            rx_bit_vld_d = 1'b1;
                        end else if (half_pend) begin
                            half_pend_d  = 1'b0;
                            rx_bit_d     = 1'b1;
                            rx_bit_vld_d = 1'b1;
                        end else begin
                            half_pend_d = 1'b1;
                        end
                    end else if (timeout) begin
                        state_d     = ST_IDLE;
                        rx_end_d    = 1'b1;
                        half_pend_d = 1'b0;
                        if (half_pend) begin
                            rx_err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            state      <= ST_IDLE;
            acc        <= '0;
            iv_n       <= '0;
            half_pend  <= 1'b0;
            rx_bit     <= 1'b0;
            rx_bit_vld <= 1'b0;
            rx_end     <= 1'b0;
            rx_err     <= 1'b0;
            ui_len     <= '0;
            rx_active  <= 1'b0;
            cc_idle    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the values
            // from before this edge, so the sync chain shifts one stage per clock.
            s1         <= comp_cc;
            s2         <= s1;
            s3         <= s2;
            cnt        <= cnt_d;
            state      <= state_d;
            acc        <= acc_d;
            iv_n       <= iv_n_d;
            half_pend  <= half_pend_d;
            rx_bit     <= rx_bit_d;
            rx_bit_vld <= rx_bit_vld_d;
            rx_end     <= rx_end_d;
            rx_err     <= rx_err_d;
            ui_len     <= ui_len_d;
            rx_active  <= (state_d != ST_IDLE);
            cc_idle    <= (state_d == ST_IDLE);
        end
    end

endmodule
